register_file_ctrl: RTL and testbench

Synchronous access controller that sits directly upstream of `register_file`. It accepts single read/write requests over a valid/ready handshake and sequences the asynchronous `cs_n`/`ws`/`oe`/`address`/`data` pins of the register file with programmable setup, strobe and hold/turnaround phases. It returns read data on a one-cycle response strobe. It owns the bidirectional data bus on the controller side and guarantees no bus contention with the register file's read driver.

---
 rtl/register_file_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_register_file_ctrl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/register_file_ctrl.sv
// rtl/register_file_ctrl.sv - valid/ready access sequencer for the asynchronous register_file pins
//
// Purpose:
//   Accepts one read or write request at a time. It drives cs_no/ws_o/oe_o/address_o/data_io
//   of register_file through setup, strobe and hold/turnaround phases, which have programmable
//   lengths. It returns a one-cycle response pulse when the access completes. Every pin and
//   rsp_* output comes straight from a flop. The flops load from the next-state decode, so no
//   combinational path runs from the request inputs to the pins.
//
// Ports:
//   clk_i        in   clock, rising edge
//   rst_i        in   synchronous active-high reset
//   req_valid_i  in   request present (held by requester until accepted)
//   req_ready_o  out  controller idle, request accepted at this cycle's closing edge
//   req_write_i  in   1 = write, 0 = read
//   req_addr_i   in   target address [Depth]
//   req_wdata_i  in   write data [Width]
//   rsp_valid_o  out  one-cycle completion pulse (first IDLE cycle after an access)
//   rsp_write_o  out  type of the completed access
//   rsp_rdata_o  out  data of the last completed read, held across writes
//   cs_no        out  register file chip select, active-low
//   ws_o         out  register file write strobe (commits on rising edge)
//   oe_o         out  register file output enable
//   address_o    out  register file address [Depth]
//   data_io      io   register file data bus [Width], driven only during write phases

module register_file_ctrl #(
  parameter int Width        = 8,
  parameter int Depth        = 5,
  parameter int SetupCycles  = 1,
  parameter int StrobeCycles = 2,
  parameter int HoldCycles   = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic             req_write_i,
  input  logic [Depth-1:0] req_addr_i,
  input  logic [Width-1:0] req_wdata_i,
  output logic             rsp_valid_o,
  output logic             rsp_write_o,
  output logic [Width-1:0] rsp_rdata_o,
  output logic             cs_no,
  output logic             ws_o,
  output logic             oe_o,
  output logic [Depth-1:0] address_o,
  inout  wire  [Width-1:0] data_io
);

  typedef enum logic [2:0] {
    IDLE,
    W_SETUP,
    W_STROBE,
    W_HOLD,
    R_SETUP,
    R_ENABLE,
    R_TURN
  } state_t;

  // Phase counter reload values: a phase of N cycles counts N-1 down to 0.
  localparam logic [3:0] SetupLoad  = 4'(SetupCycles - 1);
  localparam logic [3:0] StrobeLoad = 4'(StrobeCycles - 1);
  localparam logic [3:0] HoldLoad   = 4'(HoldCycles - 1);

  state_t             state;
  state_t             state_d;
  logic [3:0]         phase;
  logic [3:0]         phase_d;
  logic               accept;
  logic               capture;
  logic               done;
  logic               drive;
  logic [Width-1:0]   wdata_q;

  // Next-state decode. accept uses the registered req_ready_o, which is high exactly in IDLE.
  always_comb begin
    state_d = state;
    phase_d = phase;
    accept  = 1'b0;
    capture = 1'b0;
    done    = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid_i && req_ready_o) begin
          accept  = 1'b1;
          phase_d = SetupLoad;
          state_d = req_write_i ? W_SETUP : R_SETUP;
        end
      end
      W_SETUP: begin
        if (phase == 4'd0) begin
          state_d = W_STROBE;
          phase_d = StrobeLoad;
        end else begin
          phase_d = phase - 4'd1;
        end
      end
      W_STROBE: begin
        if (phase == 4'd0) begin
          state_d = W_HOLD;
          phase_d = HoldLoad;
        end else begin
          phase_d = phase - 4'd1;
        end
      end
      W_HOLD: begin
        if (phase == 4'd0) begin
          state_d = IDLE;
          done    = 1'b1;
        end else begin
          phase_d = phase - 4'd1;
        end
      end
      R_SETUP: begin
        if (phase == 4'd0) begin
          state_d = R_ENABLE;
          phase_d = StrobeLoad;
        end else begin
          phase_d = phase - 4'd1;
        end
      end
      R_ENABLE: begin
        // Sample the bus on the closing edge of the last enable cycle, while oe_o is still high.
        if (phase == 4'd0) begin
          state_d = R_TURN;
          phase_d = HoldLoad;
          capture = 1'b1;
        end else begin
          phase_d = phase - 4'd1;
        end
      end
      R_TURN: begin
        if (phase == 4'd0) begin
          state_d = IDLE;
          done    = 1'b1;
        end else begin
          phase_d = phase - 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
        phase_d = 4'd0;
      end
    endcase
  end

  // State register and pin flops. The pins are decoded from state_d, so they change on the
  // same edge as the state. The pins therefore always match the state they belong to.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      phase       <= 4'd0;
      req_ready_o <= 1'b1;
      cs_no       <= 1'b1;
      ws_o        <= 1'b0;
      oe_o        <= 1'b0;
      drive       <= 1'b0;
      address_o   <= '0;
      wdata_q     <= '0;
      rsp_valid_o <= 1'b0;
      rsp_write_o <= 1'b0;
      rsp_rdata_o <= '0;
    end else begin
      state       <= state_d;
      phase       <= phase_d;
      req_ready_o <= (state_d == IDLE);
      // R_TURN deselects the chip so the register file releases the bus before any next write.
      cs_no       <= !(state_d inside {W_SETUP, W_STROBE, W_HOLD, R_SETUP, R_ENABLE});
      ws_o        <= (state_d == W_STROBE);
      oe_o        <= (state_d == R_ENABLE);
      drive       <= (state_d inside {W_SETUP, W_STROBE, W_HOLD});
      if (accept) begin
        address_o <= req_addr_i;
        wdata_q   <= req_wdata_i;
      end
      rsp_valid_o <= done;
      if (done) begin
        rsp_write_o <= (state == W_HOLD);
      end
      if (capture) begin
        rsp_rdata_o <= data_io;
      end
    end
  end

  assign data_io = drive ? wdata_q : {Width{1'bz}};

endmodule

// File: tb/tb_register_file_ctrl.sv
// tb/tb_register_file_ctrl.sv - directed, table-driven bench for register_file_ctrl

module tb_register_file_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       valid = 1'b0;
  logic       wr = 1'b0;
  logic [4:0] addr = '0;
  logic [7:0] wd = '0;
  int         sel = 0;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  // Instance a: default timing.
  logic       a_ready, a_rv, a_rw, a_cs, a_ws, a_oe;
  logic [7:0] a_rd;
  logic [4:0] a_ad;
  wire  [7:0] a_bus;
  logic [7:0] mem_a [32];

  register_file_ctrl u_a (
    .clk_i(clk), .rst_i(rst), .req_valid_i(valid && sel == 0), .req_ready_o(a_ready),
    .req_write_i(wr), .req_addr_i(addr), .req_wdata_i(wd),
    .rsp_valid_o(a_rv), .rsp_write_o(a_rw), .rsp_rdata_o(a_rd),
    .cs_no(a_cs), .ws_o(a_ws), .oe_o(a_oe), .address_o(a_ad), .data_io(a_bus)
  );

  assign a_bus = (a_oe && !a_cs) ? mem_a[a_ad] : 8'bz;
  always @(posedge a_ws) if (!a_cs) mem_a[a_ad] <= a_bus;

  // Instance b: Setup=3, Strobe=1, Hold=2.
  logic       b_ready, b_rv, b_rw, b_cs, b_ws, b_oe;
  logic [7:0] b_rd;
  logic [4:0] b_ad;
  wire  [7:0] b_bus;
  logic [7:0] mem_b [32];

  register_file_ctrl #(.Width(8), .Depth(5), .SetupCycles(3), .StrobeCycles(1), .HoldCycles(2)) u_b (
    .clk_i(clk), .rst_i(rst), .req_valid_i(valid && sel == 1), .req_ready_o(b_ready),
    .req_write_i(wr), .req_addr_i(addr), .req_wdata_i(wd),
    .rsp_valid_o(b_rv), .rsp_write_o(b_rw), .rsp_rdata_o(b_rd),
    .cs_no(b_cs), .ws_o(b_ws), .oe_o(b_oe), .address_o(b_ad), .data_io(b_bus)
  );

  assign b_bus = (b_oe && !b_cs) ? mem_b[b_ad] : 8'bz;
  always @(posedge b_ws) if (!b_cs) mem_b[b_ad] <= b_bus;

  // Selected-instance view.
  logic       s_ready, s_rv, s_rw, s_cs, s_ws, s_oe;
  logic [7:0] s_rd;
  logic [4:0] s_ad;
  always_comb begin
    if (sel == 0) begin
      s_ready = a_ready; s_rv = a_rv; s_rw = a_rw; s_cs = a_cs;
      s_ws = a_ws; s_oe = a_oe; s_rd = a_rd; s_ad = a_ad;
    end else begin
      s_ready = b_ready; s_rv = b_rv; s_rw = b_rw; s_cs = b_cs;
      s_ws = b_ws; s_oe = b_oe; s_rd = b_rd; s_ad = b_ad;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Issue one request from a negedge. Valid stays high afterwards (caller drops it), so it
  // is also held through the busy cycles. Returns at the negedge of the rsp_valid cycle.
  task automatic req(input logic w, input logic [4:0] ad, input logic [7:0] d,
                     output int lat, output int csl, output int stb, output int st0,
                     output time tacc);
    int n;
    int first_cs;
    int first_st;
    wr = w; addr = ad; wd = d; valid = 1'b1;
    n = 0;
    while (!s_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!s_ready) chk("accept_timeout", 32'd1, 32'd0);
    @(posedge clk);
    tacc = $time;
    lat = -1; csl = 0; stb = 0; first_cs = -1; first_st = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (s_oe) chk("ws_during_oe", {31'd0, s_ws}, 32'd0);
      if (s_rv) begin
        lat = k - 1;
        break;
      end
      if (k == 1) chk("ready_busy", {31'd0, s_ready}, 32'd0);
      if (!s_cs) begin
        csl++;
        if (first_cs < 0) first_cs = k;
      end
      if (s_ws || s_oe) begin
        stb++;
        if (first_st < 0) first_st = k;
      end
    end
    if (lat < 0) chk("rsp_timeout", 32'd1, 32'd0);
    st0 = first_st - first_cs;
  endtask

  typedef struct {
    logic       w;
    logic [4:0] a;
    logic [7:0] d;
    logic [7:0] exp_rd;
  } vec_t;

  vec_t tbl[$];

  initial begin
    int   lat, csl, stb, st0, rv_cnt;
    time  tacc, tprev;
    logic [7:0] prev_rd;

    // Single write/read of 0xA5 at 5, then walking ones with each write between two reads.
    tbl.push_back('{1'b1, 5'd5, 8'hA5, 8'h00});
    tbl.push_back('{1'b0, 5'd5, 8'h00, 8'hA5});
    prev_rd = 8'hA5;
    for (int i = 0; i < 8; i++) begin
      tbl.push_back('{1'b1, 5'(i), 8'(1 << i), prev_rd});
      tbl.push_back('{1'b0, 5'(i), 8'h00, 8'(1 << i)});
      prev_rd = 8'(1 << i);
    end

    // Reset held with a pending write request.
    sel = 0; rst = 1'b1; valid = 1'b1; wr = 1'b1; addr = 5'd5; wd = 8'h11;
    @(posedge clk);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("rst_cs", {31'd0, a_cs}, 32'd1);
      chk("rst_ws", {31'd0, a_ws}, 32'd0);
      chk("rst_oe", {31'd0, a_oe}, 32'd0);
      chk("rst_rv", {31'd0, a_rv}, 32'd0);
      chk("rst_ready", {31'd0, a_ready}, 32'd1);
    end
    chk("rst_addr", {27'd0, a_ad}, 32'd0);
    chk("rst_rd", {24'd0, a_rd}, 32'd0);
    chk("rst_rw", {31'd0, a_rw}, 32'd0);
    rst = 1'b0; valid = 1'b0;
    @(negedge clk);
    chk("post_rst_cs", {31'd0, a_cs}, 32'd1);
    chk("post_rst_ready", {31'd0, a_ready}, 32'd1);

    // Table: default timing, write 4 cycles cs low, read 3 (turnaround deselects).
    foreach (tbl[i]) begin
      req(tbl[i].w, tbl[i].a, tbl[i].d, lat, csl, stb, st0, tacc);
      chk("tbl_rw", {31'd0, a_rw}, {31'd0, tbl[i].w});
      chk("tbl_rd", {24'd0, a_rd}, {24'd0, tbl[i].exp_rd});
      chk("tbl_lat", lat, 32'd4);
      chk("tbl_cs_low", csl, tbl[i].w ? 32'd4 : 32'd3);
      chk("tbl_strobe", stb, 32'd2);
      chk("tbl_strobe_start", st0, 32'd1);
    end
    valid = 1'b0;
    @(negedge clk);

    // Fill/readback with valid held high: one accept every 5 cycles.
    tprev = 0;
    for (int i = 0; i < 64; i++) begin
      req(i < 32 ? 1'b1 : 1'b0, 5'(i % 32), 8'(i % 32), lat, csl, stb, st0, tacc);
      if (i > 0) chk("fill_period", 32'(tacc - tprev), 32'd50);
      if (i >= 32) chk("fill_rd", {24'd0, a_rd}, 32'(i % 32));
      tprev = tacc;
    end
    valid = 1'b0;

    // Known-zero read data before the aborted read.
    req(1'b1, 5'd31, 8'h00, lat, csl, stb, st0, tacc);
    req(1'b0, 5'd31, 8'h00, lat, csl, stb, st0, tacc);
    valid = 1'b0;
    chk("zero_rd", {24'd0, a_rd}, 32'd0);

    // Reset during the second enable cycle of a read of address 9 (holds 9).
    wr = 1'b0; addr = 5'd9; valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("abort_r_oe_before", {31'd0, a_oe}, 32'd1);
    rst = 1'b1; valid = 1'b0;
    @(negedge clk);
    chk("abort_r_oe", {31'd0, a_oe}, 32'd0);
    chk("abort_r_cs", {31'd0, a_cs}, 32'd1);
    chk("abort_r_rv", {31'd0, a_rv}, 32'd0);
    chk("abort_r_rd", {24'd0, a_rd}, 32'd0);
    rst = 1'b0;
    rv_cnt = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (a_rv) rv_cnt++;
    end
    chk("abort_r_no_rsp", rv_cnt, 32'd0);

    // Reset during W_SETUP of a write of 0xEE to address 10 (holds 10).
    wr = 1'b1; addr = 5'd10; wd = 8'hEE; valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("abort_w_setup_cs", {31'd0, a_cs}, 32'd0);
    chk("abort_w_setup_ws", {31'd0, a_ws}, 32'd0);
    rst = 1'b1; valid = 1'b0;
    @(negedge clk);
    chk("abort_w_cs", {31'd0, a_cs}, 32'd1);
    chk("abort_w_rv", {31'd0, a_rv}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    req(1'b0, 5'd10, 8'h00, lat, csl, stb, st0, tacc);
    valid = 1'b0;
    chk("abort_w_readback", {24'd0, a_rd}, 32'h0A);

    // Setup=3, Strobe=1, Hold=2: latency 6, period 7.
    sel = 1;
    @(negedge clk);
    req(1'b1, 5'd3, 8'h5A, lat, csl, stb, st0, tacc);
    chk("p_w_lat", lat, 32'd6);
    chk("p_w_cs_low", csl, 32'd6);
    chk("p_w_strobe", stb, 32'd1);
    chk("p_w_strobe_start", st0, 32'd3);
    chk("p_w_rw", {31'd0, b_rw}, 32'd1);
    tprev = tacc;
    req(1'b1, 5'd4, 8'hC3, lat, csl, stb, st0, tacc);
    chk("p_period", 32'(tacc - tprev), 32'd70);
    req(1'b0, 5'd3, 8'h00, lat, csl, stb, st0, tacc);
    chk("p_r_lat", lat, 32'd6);
    chk("p_r_cs_low", csl, 32'd4);
    chk("p_r_oe", stb, 32'd1);
    chk("p_r_oe_start", st0, 32'd3);
    chk("p_r_rw", {31'd0, b_rw}, 32'd0);
    chk("p_r_rd", {24'd0, b_rd}, 32'h5A);
    req(1'b0, 5'd4, 8'h00, lat, csl, stb, st0, tacc);
    valid = 1'b0;
    chk("p_r_rd2", {24'd0, b_rd}, 32'hC3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
